// File: rtl/shreg_pkg.sv
// Shared types for the shift-register command front-end:
// mode encoding, sequencer states and the default register width.
package shreg_pkg;

    localparam int SHREG_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/shreg_step_counter.sv
// Loadable down-counter for the remaining shift clocks.
// Ports: clk, rst (async active-low), load/load_val, dec, is_one, is_zero.
module shreg_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one  = (cnt == CNT_W'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/shreg_cmd_sequencer.sv
// Command front-end for an 8-bit universal shift register: one load/shift
// command per valid/ready handshake, drives mode/pi/sln then pulses done.
// Ports: clk, rst (async active-low), cmd_* handshake/command, po feedback,
// mode/pi/sln to the register, busy, done.
// Option macro SHREG_CTRL_ROTATE_EN: when defined, a command with cmd_rot=1
// takes its fill bit from po (po[0] right, po[WIDTH-1] left) every shift cycle.
module shreg_cmd_sequencer
    import shreg_pkg::*;
#(
    parameter int WIDTH = SHREG_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_sin,
    input  logic             cmd_rot,
    input  logic [WIDTH-1:0] po,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] sln,
    output logic             busy,
    output logic             done
);

    state_e           state, state_n;
    mode_e            mode_q, mode_n;
    logic [WIDTH-1:0] pi_q, pi_n;
    logic [WIDTH-1:0] sln_q, sln_n;
    logic             done_q, done_n;

    mode_e            op_q;
    logic             sin_q;
    logic             lat_en;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_one;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_clamp;
    logic             fill_start;
    logic             fill_run;

    assign cnt_clamp = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

    shreg_step_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_clamp),
        .dec      (cnt_dec),
        .is_one   (cnt_one),
        .is_zero  (cnt_zero)
    );

`ifdef SHREG_CTRL_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rot_q <= 1'b0;
        end else if (lat_en) begin
            rot_q <= cmd_rot;
        end
    end

    // Fill for the first shift cycle comes from the live command, later
    // cycles from the latched copy; both tap the current po when rotating.
    assign fill_start = cmd_rot
        ? ((cmd_op == MODE_SHL) ? po[WIDTH-1] : po[0])
        : cmd_sin;
    assign fill_run = rot_q
        ? ((op_q == MODE_SHL) ? po[WIDTH-1] : po[0])
        : sin_q;
`else
    logic unused_rot;

    assign unused_rot = ^{cmd_rot, po};
    assign fill_start = cmd_sin;
    assign fill_run   = sin_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= MODE_HOLD;
            sin_q <= 1'b0;
        end else if (lat_en) begin
            op_q  <= mode_e'(cmd_op);
            sin_q <= cmd_sin;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= MODE_HOLD;
            pi_q   <= '0;
            sln_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            pi_q   <= pi_n;
            sln_q  <= sln_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = MODE_HOLD;
        pi_n     = pi_q;
        sln_n    = sln_q;
        done_n   = 1'b0;
        lat_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    lat_en   = 1'b1;
                    cnt_load = 1'b1;
                    if (cmd_op == MODE_LOAD) begin
                        state_n = LOAD;
                        mode_n  = MODE_LOAD;
                        pi_n    = cmd_data;
                    end else if ((cmd_op != MODE_HOLD) && (cnt_clamp != '0)) begin
                        state_n = SHIFT;
                        mode_n  = mode_e'(cmd_op);
                        sln_n   = {WIDTH{fill_start}};
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            SHIFT: begin
                // is_zero is only a guard; a shift always enters with count>0
                if (cnt_one || cnt_zero) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    mode_n  = op_q;
                    cnt_dec = 1'b1;
                    sln_n   = {WIDTH{fill_run}};
                end
            end
            DONE: begin
                state_n = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mode      = mode_q;
    assign pi        = pi_q;
    assign sln       = sln_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shreg_cmd_sequencer.sv
// Directed self-checking bench for shreg_cmd_sequencer.
// Rotate expectations follow SHREG_CTRL_ROTATE_EN when the macro is set.
module tb_shreg_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_count;
    logic       cmd_sin;
    logic       cmd_rot;
    logic [7:0] po;
    logic [1:0] mode;
    logic [7:0] pi;
    logic [7:0] sln;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shreg_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .cmd_sin   (cmd_sin),
        .cmd_rot   (cmd_rot),
        .po        (po),
        .mode      (mode),
        .pi        (pi),
        .sln       (sln),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d,
                         input logic [3:0] c, input logic s, input logic r);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = c;
        cmd_sin   = s;
        cmd_rot   = r;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        int dn;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        cmd_count = 4'd0;
        cmd_sin   = 1'b0;
        cmd_rot   = 1'b0;
        po        = 8'h00;
        #1;
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_pi", 32'(pi), 32'h0);
        chk("rst_sln", 32'(sln), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        #11 rst = 1'b1;
        tick();

        // load A5
        issue(2'b11, 8'hA5, 4'd0, 1'b0, 1'b0);
        chk("ld_mode", 32'(mode), 32'h3);
        chk("ld_pi", 32'(pi), 32'hA5);
        chk("ld_ready", 32'(cmd_ready), 32'h0);
        chk("ld_busy", 32'(busy), 32'h1);
        chk("ld_done0", 32'(done), 32'h0);
        tick();
        chk("ld_mode_off", 32'(mode), 32'h0);
        chk("ld_done", 32'(done), 32'h1);
        chk("ld_ready_lo", 32'(cmd_ready), 32'h0);
        tick();
        chk("ld_done_end", 32'(done), 32'h0);
        chk("ld_ready_back", 32'(cmd_ready), 32'h1);

        // shift right 3, fill 1
        issue(2'b01, 8'h00, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("shr_mode%0d", i), 32'(mode), 32'h1);
            chk($sformatf("shr_sln%0d", i), 32'(sln), 32'hFF);
            chk($sformatf("shr_done%0d", i), 32'(done), 32'h0);
            tick();
        end
        chk("shr_mode_off", 32'(mode), 32'h0);
        chk("shr_done", 32'(done), 32'h1);
        chk("shr_pi_hold", 32'(pi), 32'hA5);
        tick();
        chk("shr_ready", 32'(cmd_ready), 32'h1);

        // zero-length left shift
        issue(2'b10, 8'h00, 4'd0, 1'b1, 1'b0);
        chk("z_mode", 32'(mode), 32'h0);
        chk("z_done", 32'(done), 32'h1);
        chk("z_busy", 32'(busy), 32'h1);
        tick();
        chk("z_ready", 32'(cmd_ready), 32'h1);
        chk("z_done_end", 32'(done), 32'h0);

        // hold op with nonzero count
        issue(2'b00, 8'h00, 4'd3, 1'b0, 1'b0);
        chk("h_mode", 32'(mode), 32'h0);
        chk("h_done", 32'(done), 32'h1);
        tick();

        // left shift 15 clamps to 8
        issue(2'b10, 8'h00, 4'd15, 1'b0, 1'b0);
        chk("cl_sln", 32'(sln), 32'h00);
        n = 0;
        while (mode == 2'b10 && n < 20) begin
            n++;
            tick();
        end
        chk("cl_len", 32'(n), 32'd8);
        chk("cl_done", 32'(done), 32'h1);
        tick();

        // busy: competing command held during shift of 4
        issue(2'b01, 8'h00, 4'd4, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_data  = 8'h3C;
        n = 0;
        while (mode == 2'b01 && n < 20) begin
            n++;
            tick();
        end
        chk("bz_len", 32'(n), 32'd4);
        chk("bz_done", 32'(done), 32'h1);
        chk("bz_pi", 32'(pi), 32'hA5);
        cmd_valid = 1'b0;
        tick();
        chk("bz_idle_mode", 32'(mode), 32'h0);
        chk("bz_ready", 32'(cmd_ready), 32'h1);

        // abort at 2nd shift cycle
        issue(2'b01, 8'h00, 4'd5, 1'b1, 1'b0);
        tick();
        chk("ab_mode_pre", 32'(mode), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("ab_mode", 32'(mode), 32'h0);
        chk("ab_pi", 32'(pi), 32'h0);
        chk("ab_sln", 32'(sln), 32'h0);
        chk("ab_ready", 32'(cmd_ready), 32'h1);
        tick();
        rst = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dn++;
        end
        chk("ab_no_done", 32'(dn), 32'd0);
        chk("ab_idle_mode", 32'(mode), 32'h0);

        // rotate request: po feedback vs latched sin
        po = 8'h01;
        issue(2'b01, 8'h00, 4'd2, 1'b1, 1'b1);
        chk("rot_sln0", 32'(sln), 32'hFF);
        chk("rot_mode0", 32'(mode), 32'h1);
        po = 8'h00;
        tick();
`ifdef SHREG_CTRL_ROTATE_EN
        chk("rot_sln1", 32'(sln), 32'h00);
`else
        chk("rot_sln1", 32'(sln), 32'hFF);
`endif
        chk("rot_mode1", 32'(mode), 32'h1);
        tick();
        chk("rot_done", 32'(done), 32'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
